// File: rtl/otp_pkg.sv
// otp_pkg: shared state/command types and timer sizing for the OTP sequencer
package otp_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_RD_SETUP, S_RD_WAIT, S_VPP_ON, S_PG_SETUP, S_PG_PULSE, S_PG_HOLD, S_PG_NEXT, S_RESP
  } state_t;
  typedef enum logic {CMD_RD = 1'b0, CMD_PG = 1'b1} cmd_t;
  function automatic int tmr_w(input int rd, input int su, input int pg, input int vp);
    int m;
    m = rd;
    m = su > m ? su : m;
    m = pg > m ? pg : m;
    m = vp > m ? vp : m;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/otp_tmr.sv
// otp_tmr: loadable down-counter; done is high once the count has reached zero
module otp_tmr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign done = cnt == '0;
endmodule

// File: rtl/otp_ctl.sv
// otp_ctl: sequences host read/program requests into OTP macro CSB/RE/PGM/VPP timing
module otp_ctl import otp_pkg::*; #(
  parameter int DW        = 8,
  parameter int WAW       = 13,
  parameter int BAW       = $clog2(DW),
  parameter int RD_CYC    = 2,
  parameter int SETUP_CYC = 2,
  parameter int PGM_CYC   = 100,
  parameter int VPP_CYC   = 50,
  parameter bit VERIFY    = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_wr,
  input  logic [WAW-1:0]     req_addr,
  input  logic [DW-1:0]      req_wdata,
  output logic               rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic [WAW+BAW-1:0] otp_a,
  output logic               otp_csb,
  output logic               otp_re,
  output logic               otp_pgm,
  output logic               otp_vpp_en,
  input  logic [DW-1:0]      otp_q
);
  localparam int TW = tmr_w(RD_CYC, SETUP_CYC, PGM_CYC, VPP_CYC);
  localparam logic [TW-1:0] RD_L = TW'(RD_CYC - 1);
  localparam logic [TW-1:0] SU_L = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] PG_L = TW'(PGM_CYC - 1);
  localparam logic [TW-1:0] VP_L = TW'(VPP_CYC - 1);
  state_t        state;
  cmd_t          cmd;
  logic [DW-1:0] wdata, rem, rem_nxt;
  logic [TW-1:0] ld_val;
  logic          ld, done, acc;
  function automatic logic [BAW-1:0] low_bit(input logic [DW-1:0] m);
    logic [BAW-1:0] r;
    r = '0;
    for (int i = DW - 1; i >= 0; i--) if (m[i]) r = BAW'(i);
    return r;
  endfunction
  assign acc     = req_valid && req_ready;
  assign rem_nxt = rem & (rem - DW'(1));
  // the timer is reloaded on entry to every timed state; spare loads are harmless
  assign ld      = state inside {S_IDLE, S_RD_SETUP, S_PG_NEXT} ||
                   (done && state inside {S_VPP_ON, S_PG_SETUP, S_PG_PULSE});
  assign ld_val  = state == S_IDLE ? VP_L : state == S_RD_SETUP ? RD_L :
                   state == S_PG_SETUP ? PG_L : SU_L;
  otp_tmr #(.W(TW)) u_tmr (
    .clk  (clk),
    .rst  (rst),
    .load (ld),
    .val  (ld_val),
    .done (done)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cmd        <= CMD_RD;
      wdata      <= '0;
      rem        <= '0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      otp_a      <= '0;
      otp_csb    <= 1'b1;
      otp_re     <= 1'b0;
      otp_pgm    <= 1'b0;
      otp_vpp_en <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          req_ready <= !acc;
          if (acc) begin
            cmd   <= cmd_t'(req_wr);
            wdata <= req_wdata;
            rem   <= req_wdata;
            otp_a <= {req_wr ? low_bit(req_wdata) : BAW'(0), req_addr};
            if (req_wr && req_wdata != '0) begin
              state      <= S_VPP_ON;
              otp_vpp_en <= 1'b1;
            end else if (req_wr && !VERIFY) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
            end else begin
              state   <= S_RD_SETUP;
              otp_csb <= 1'b0;
            end
          end
        end
        S_RD_SETUP: begin
          state  <= S_RD_WAIT;
          otp_re <= 1'b1;
        end
        S_RD_WAIT:
          if (done) begin
            state     <= S_RESP;
            otp_re    <= 1'b0;
            otp_csb   <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_rdata <= otp_q;
            rsp_err   <= cmd == CMD_PG && (otp_q & wdata) != wdata;
          end
        S_VPP_ON:
          if (done) begin
            state   <= S_PG_SETUP;
            otp_csb <= 1'b0;
          end
        S_PG_SETUP:
          if (done) begin
            state   <= S_PG_PULSE;
            otp_pgm <= 1'b1;
          end
        S_PG_PULSE:
          if (done) begin
            state   <= S_PG_HOLD;
            otp_pgm <= 1'b0;
          end
        S_PG_HOLD:
          if (done) begin
            state               <= S_PG_NEXT;
            otp_csb             <= 1'b1;
            rem                 <= rem_nxt;
            otp_a[WAW +: BAW]   <= low_bit(rem_nxt);
          end
        S_PG_NEXT:
          if (rem != '0) begin
            state   <= S_PG_SETUP;
            otp_csb <= 1'b0;
          end else if (VERIFY) begin
            state      <= S_RD_SETUP;
            otp_csb    <= 1'b0;
            otp_vpp_en <= 1'b0;
          end else begin
            state      <= S_RESP;
            otp_vpp_en <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b0;
          end
        S_RESP: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
